reflet_irq_ctrl: RTL and testbench

Parametrised, nesting interrupt controller for the Reflet CPU. It supports any number of channels, with per-channel edge or level sensing and per-channel masks. It arbitrates by fixed priority, preempts lower-priority handlers, and keeps an internal LIFO of return PCs, one entry per nesting level. It sits beside the CPU register file. The CPU consumes `interrupt`, `out_routine` and `return_pc` at instruction boundaries.

---
 rtl/reflet_irq_ctrl_pkg.sv | 15 +
 rtl/reflet_irq_stack.sv | 53 +++++
 rtl/reflet_irq_ctrl.sv | 106 ++++++++++
 tb/tb_reflet_irq_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reflet_irq_ctrl_pkg.sv
// rtl/reflet_irq_ctrl_pkg.sv - shared constants and vector-slot helper for the Reflet interrupt controller
package reflet_irq_ctrl_pkg;

  localparam int         IRQ_MAX_CHANNELS = 16;
  localparam int         IRQ_ID_W         = 4;
  localparam logic [7:0] INST_RETINT      = 8'h0A;

  // Vector slots are one CPU word apart, starting at the channel-0 slot.
  function automatic logic [63:0] vector_slot(input logic [63:0] base,
                                              input logic [IRQ_ID_W-1:0] id,
                                              input int wsize);
    return base + 64'(id) * 64'(wsize / 8);
  endfunction

endpackage

// File: rtl/reflet_irq_stack.sv
// rtl/reflet_irq_stack.sv - return LIFO holding {previous active id, return pc}, one entry per nesting level
module reflet_irq_stack #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    sp_q, sp_d;
  logic [IW-1:0]    wr_idx, top_idx;
  logic             full;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == PW'(DEPTH));
  assign wr_idx  = sp_q[IW-1:0];
  assign top_idx = IW'(sp_q - PW'(1));
  assign top     = empty ? '0 : mem_q[top_idx];

  always_comb begin
    sp_d = sp_q;
    if (push && !full) begin
      sp_d = sp_q + PW'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Contents need no reset: an empty stack masks whatever is stored.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/reflet_irq_ctrl.sv
// rtl/reflet_irq_ctrl.sv - nesting fixed-priority interrupt controller for the Reflet CPU
module reflet_irq_ctrl
  import reflet_irq_ctrl_pkg::*;
#(
  parameter int          wordsize    = 16,
  parameter int          channels    = 4,
  parameter logic [63:0] vector_base = 64'h0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [channels-1:0] irq_in,
  input  logic [channels-1:0] edge_mode,
  input  logic [channels-1:0] int_mask,
  input  logic                cpu_update,
  input  logic                ret_int,
  input  logic [wordsize-1:0] program_counter,
  output logic                interrupt,
  output logic [wordsize-1:0] out_routine,
  output logic [wordsize-1:0] return_pc,
  output logic                ret_ack,
  output logic                spurious_ret,
  output logic                in_interrupt_context,
  output logic [3:0]          active_id
);

  localparam int EW = wordsize + IRQ_ID_W;

  logic [channels-1:0] pending_q, pending_d, irq_prev_q, irq_prev_d;
  logic [IRQ_ID_W-1:0] active_id_q, active_id_d, cand;
  logic                cand_valid, spurious_q, spurious_d, stk_empty;
  logic [EW-1:0]       stk_top;

  assign in_interrupt_context = ~stk_empty;
  assign active_id            = active_id_q;
  assign spurious_ret         = spurious_q;
  assign return_pc            = stk_top[wordsize-1:0];

  // Lowest index wins; while nested only strictly higher priority may preempt.
  always_comb begin
    cand_valid = 1'b0;
    cand       = '0;
    for (int i = channels - 1; i >= 0; i--) begin
      if (pending_q[i] && int_mask[i] && (stk_empty || IRQ_ID_W'(i) < active_id_q)) begin
        cand_valid = 1'b1;
        cand       = IRQ_ID_W'(i);
      end
    end
  end

  assign ret_ack     = enable & cpu_update & ret_int & in_interrupt_context;
  assign interrupt   = enable & cpu_update & cand_valid & ~(ret_int & in_interrupt_context);
  assign out_routine = cand_valid ? wordsize'(vector_slot(vector_base, cand, wordsize)) : '0;

  always_comb begin
    pending_d   = pending_q;
    irq_prev_d  = irq_prev_q;
    active_id_d = active_id_q;
    spurious_d  = enable & cpu_update & ret_int & stk_empty;
    if (enable) begin
      irq_prev_d = irq_in;
      for (int i = 0; i < channels; i++) begin
        // A fresh edge in the take cycle re-arms the channel rather than being lost.
        if (edge_mode[i]) begin
          pending_d[i] = (pending_q[i] & ~(interrupt & (cand == IRQ_ID_W'(i))))
                       | (irq_in[i] & ~irq_prev_q[i]);
        end else begin
          pending_d[i] = irq_in[i];
        end
      end
      if (interrupt) begin
        active_id_d = cand;
      end else if (ret_ack) begin
        active_id_d = stk_top[EW-1:wordsize];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q   <= '0;
      irq_prev_q  <= '0;
      active_id_q <= '0;
      spurious_q  <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      irq_prev_q  <= irq_prev_d;
      active_id_q <= active_id_d;
      spurious_q  <= spurious_d;
    end
  end

  reflet_irq_stack #(
    .WIDTH(EW),
    .DEPTH(channels)
  ) u_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (interrupt),
    .pop      (ret_ack),
    .push_data({active_id_q, program_counter}),
    .top      (stk_top),
    .empty    (stk_empty)
  );

endmodule

// File: tb/tb_reflet_irq_ctrl.sv
// tb/tb_reflet_irq_ctrl.sv - scoreboard bench for reflet_irq_ctrl (4ch/16b and 8ch/32b instances)
module tb_reflet_irq_ctrl;

  localparam int EV_INT  = 0;
  localparam int EV_RET  = 1;
  localparam int EV_SPUR = 2;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        enable_a, cpu_update_a, ret_int_a;
  logic [3:0]  irq_a, edge_a, mask_a;
  logic [15:0] pc_a, out_routine_a, return_pc_a;
  logic        interrupt_a, ret_ack_a, spurious_a, ctx_a;
  logic [3:0]  active_a;

  logic        enable_b, cpu_update_b, ret_int_b;
  logic [7:0]  irq_b, edge_b, mask_b;
  logic [31:0] pc_b, out_routine_b, return_pc_b;
  logic        interrupt_b, ret_ack_b, spurious_b, ctx_b;
  logic [3:0]  active_b;

  int  checks = 0;
  int  errors = 0;
  ev_t qa[$];
  ev_t qb[$];

  reflet_irq_ctrl #(.wordsize(16), .channels(4), .vector_base(64'h0)) dut_a (
    .clk(clk), .reset(reset), .enable(enable_a), .irq_in(irq_a), .edge_mode(edge_a),
    .int_mask(mask_a), .cpu_update(cpu_update_a), .ret_int(ret_int_a),
    .program_counter(pc_a), .interrupt(interrupt_a), .out_routine(out_routine_a),
    .return_pc(return_pc_a), .ret_ack(ret_ack_a), .spurious_ret(spurious_a),
    .in_interrupt_context(ctx_a), .active_id(active_a)
  );

  reflet_irq_ctrl #(.wordsize(32), .channels(8), .vector_base(64'h100)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .irq_in(irq_b), .edge_mode(edge_b),
    .int_mask(mask_b), .cpu_update(cpu_update_b), .ret_int(ret_int_b),
    .program_counter(pc_b), .interrupt(interrupt_b), .out_routine(out_routine_b),
    .return_pc(return_pc_b), .ret_ack(ret_ack_b), .spurious_ret(spurious_b),
    .in_interrupt_context(ctx_b), .active_id(active_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic pop_a(input string name, input int kind, input logic [31:0] act);
    ev_t e;
    checks++;
    if (qa.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected event actual=%h required=none", name, act);
    end else begin
      e = qa.pop_front();
      if (e.kind != kind || e.val !== act) begin
        errors++;
        $display("FAIL %s actual kind=%0d val=%h required kind=%0d val=%h",
                 name, kind, act, e.kind, e.val);
      end
    end
  endtask

  task automatic exp_a(input int kind, input logic [31:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    qa.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (interrupt_a && ret_ack_a) begin
      checks++;
      errors++;
      $display("FAIL a_take_and_return actual=both required=one");
    end
    if (interrupt_a)  pop_a("a_interrupt", EV_INT, 32'(out_routine_a));
    if (ret_ack_a)    pop_a("a_ret_ack", EV_RET, 32'(return_pc_a));
    if (spurious_a)   pop_a("a_spurious", EV_SPUR, 32'h0);
  end

  always @(negedge clk) begin
    ev_t e;
    if (interrupt_b || ret_ack_b || spurious_b) begin
      checks++;
      if (qb.size() == 0 || !interrupt_b) begin
        errors++;
        $display("FAIL b_event unexpected int=%b ret=%b spur=%b routine=%h",
                 interrupt_b, ret_ack_b, spurious_b, out_routine_b);
      end else begin
        e = qb.pop_front();
        if (e.val !== out_routine_b) begin
          errors++;
          $display("FAIL b_out_routine actual=%h required=%h", out_routine_b, e.val);
        end
      end
    end
  end

  initial begin
    ev_t eb;
    reset = 1'b1;
    enable_a = 1'b1; cpu_update_a = 1'b0; ret_int_a = 1'b0;
    irq_a = '0; edge_a = 4'b1111; mask_a = 4'b0100; pc_a = '0;
    enable_b = 1'b1; cpu_update_b = 1'b0; ret_int_b = 1'b0;
    irq_b = '0; edge_b = 8'hFF; mask_b = 8'h80; pc_b = 32'h0000_ABCD;
    step(); step();
    chk("rst_interrupt", 32'(interrupt_a), 32'h0);
    chk("rst_ret_ack", 32'(ret_ack_a), 32'h0);
    chk("rst_ctx", 32'(ctx_a), 32'h0);
    chk("rst_active_id", 32'(active_a), 32'h0);
    chk("rst_return_pc", 32'(return_pc_a), 32'h0);
    chk("rst_spurious", 32'(spurious_a), 32'h0);
    reset = 1'b0;

    // Wide instance: two ch7 edges before any update collapse into one take.
    irq_b = 8'h80; step();
    irq_b = 8'h00; step();
    irq_b = 8'h80; step();
    eb.kind = EV_INT; eb.val = 32'h11C; qb.push_back(eb);
    cpu_update_b = 1'b1; step();
    step(); step();
    chk("b_active_id", 32'(active_b), 32'h7);
    chk("b_ctx", 32'(ctx_b), 32'h1);
    chk("b_return_pc", return_pc_b, 32'h0000_ABCD);
    cpu_update_b = 1'b0;

    // ch2 taken, then preempted by ch0, then unwound.
    cpu_update_a = 1'b1; irq_a = 4'b0100; pc_a = 16'h0123;
    exp_a(EV_INT, 32'h0004);
    step();
    chk("latency_interrupt", 32'(interrupt_a), 32'h1);
    step();
    chk("ch2_active_id", 32'(active_a), 32'h2);
    chk("ch2_ctx", 32'(ctx_a), 32'h1);
    mask_a = 4'b0101; irq_a = 4'b0101; pc_a = 16'h0200;
    exp_a(EV_INT, 32'h0000);
    step(); step();
    chk("ch0_active_id", 32'(active_a), 32'h0);
    irq_a = 4'b0000; ret_int_a = 1'b1;
    exp_a(EV_RET, 32'h0200);
    step();
    chk("pop1_active_id", 32'(active_a), 32'h2);
    exp_a(EV_RET, 32'h0123);
    step();
    ret_int_a = 1'b0;
    chk("unwound_ctx", 32'(ctx_a), 32'h0);

    // Lower priority ch3 waits behind ch1, then fires after the return.
    mask_a = 4'b1111; irq_a = 4'b0010; pc_a = 16'h0300;
    exp_a(EV_INT, 32'h0002);
    step(); step();
    chk("ch1_active_id", 32'(active_a), 32'h1);
    irq_a = 4'b1010;
    step(); step();
    chk("ch3_blocked_active_id", 32'(active_a), 32'h1);
    ret_int_a = 1'b1;
    exp_a(EV_RET, 32'h0300);
    exp_a(EV_INT, 32'h0006);
    step();
    ret_int_a = 1'b0;
    step();
    chk("ch3_active_id", 32'(active_a), 32'h3);
    irq_a = 4'b0000; ret_int_a = 1'b1;
    exp_a(EV_RET, 32'h0300);
    step();
    ret_int_a = 1'b0;

    // Level ch1 pending while returning from ch2: return wins, ch1 taken next.
    edge_a = 4'b1101; irq_a = 4'b0100; pc_a = 16'h0500;
    exp_a(EV_INT, 32'h0004);
    step(); step();
    chk("lvl_ch2_active_id", 32'(active_a), 32'h2);
    cpu_update_a = 1'b0; irq_a = 4'b0110;
    step(); step();
    chk("no_update_interrupt", 32'(interrupt_a), 32'h0);
    cpu_update_a = 1'b1; ret_int_a = 1'b1;
    exp_a(EV_RET, 32'h0500);
    exp_a(EV_INT, 32'h0002);
    #1;
    chk("collide_ret_ack", 32'(ret_ack_a), 32'h1);
    chk("collide_interrupt", 32'(interrupt_a), 32'h0);
    step();
    ret_int_a = 1'b0;
    step();
    chk("lvl_ch1_active_id", 32'(active_a), 32'h1);
    irq_a = 4'b0000; ret_int_a = 1'b1;
    exp_a(EV_RET, 32'h0500);
    step();
    ret_int_a = 1'b0;
    step();
    chk("lvl_done_ctx", 32'(ctx_a), 32'h0);

    // Return with nothing to return from.
    edge_a = 4'b1111; ret_int_a = 1'b1;
    exp_a(EV_SPUR, 32'h0);
    #1;
    chk("spur_ret_ack", 32'(ret_ack_a), 32'h0);
    step();
    ret_int_a = 1'b0;
    step(); step();
    chk("spur_cleared", 32'(spurious_a), 32'h0);

    // Asynchronous reset while two levels deep.
    irq_a = 4'b0100; pc_a = 16'h0600;
    exp_a(EV_INT, 32'h0004);
    step(); step();
    irq_a = 4'b0101; pc_a = 16'h0700;
    exp_a(EV_INT, 32'h0000);
    step(); step();
    chk("nest2_return_pc", 32'(return_pc_a), 32'h0700);
    chk("nest2_ctx", 32'(ctx_a), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_ctx", 32'(ctx_a), 32'h0);
    chk("async_active_id", 32'(active_a), 32'h0);
    chk("async_return_pc", 32'(return_pc_a), 32'h0);
    chk("async_interrupt", 32'(interrupt_a), 32'h0);
    irq_a = 4'b0000; cpu_update_a = 1'b0;
    step();
    reset = 1'b0;
    step(); step();

    chk("a_queue_drained", 32'(qa.size()), 32'h0);
    chk("b_queue_drained", 32'(qb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
